// File: rtl/signal_conv_enc_pkg.sv
// Shared constants, FSM state type and helpers for the SIGNAL-field
// tail-biting convolutional encoder.
package signal_conv_enc_pkg;

  localparam int         K        = 7;
  localparam int         SIG_BITS = 32;
  localparam logic [6:0] G0_DEF   = 7'o133;
  localparam logic [6:0] G1_DEF   = 7'o171;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_ABORT = 2'd2
  } enc_state_t;

  // do_init lists the newest bit in its MSB, the shift register holds it in sr[0]
  function automatic logic [K-2:0] init_to_state(input logic [K-2:0] init);
    logic [K-2:0] s;
    for (int k = 0; k < K-1; k++) begin
      s[k] = init[K-2-k];
    end
    return s;
  endfunction

endpackage

// File: rtl/signal_conv_enc_if.sv
// Serial info-bit input and coded-pair output bundle of the SIGNAL encoder.
interface signal_conv_enc_if;

  logic       di;
  logic [5:0] di_init;
  logic       di_vld;
  logic       do_a;
  logic       do_b;
  logic       do_vld;
  logic       do_done;
  logic       tb_err;
  logic       len_err;

  modport master (
    output di, di_init, di_vld,
    input  do_a, do_b, do_vld, do_done, tb_err, len_err
  );

  modport slave (
    input  di, di_init, di_vld,
    output do_a, do_b, do_vld, do_done, tb_err, len_err
  );

endinterface

// File: rtl/signal_conv_enc_core.sv
// Combinational K=7 convolutional encoder tap network; also reused by the
// DATA-field encoder.
module conv_enc_core
  import signal_conv_enc_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         i_bit,
  input  logic [K-2:0] i_sr,
  output logic         o_a,
  output logic         o_b
);

  logic [K-1:0] w_vec;

  // Generator MSB taps the current bit, G[5-k] taps sr[k]
  always_comb begin
    w_vec[K-1] = i_bit;
    for (int k = 0; k < K-1; k++) begin
      w_vec[K-2-k] = i_sr[k];
    end
  end

  assign o_a = ^(w_vec & G0);
  assign o_b = ^(w_vec & G1);

endmodule

// File: rtl/signal_conv_enc.sv
// Tail-biting rate-1/2 encoder for the 32-bit SIGNAL segment: frame FSM,
// state/init registers and registered coded-pair outputs.
module signal_conv_enc
  import signal_conv_enc_pkg::*;
#(
  parameter int           NUM_BITS = SIG_BITS,
  parameter logic [K-1:0] G0       = G0_DEF,
  parameter logic [K-1:0] G1       = G1_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  signal_conv_enc_if.slave   bus
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  enc_state_t         r_state;
  logic [K-2:0]       r_sr;
  logic [K-2:0]       r_init_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a;
  logic               r_b;
  logic               r_vld;
  logic               r_done;
  logic               r_tb_err;
  logic               r_len_err;

  logic [K-2:0]       w_s0;
  logic [K-2:0]       w_sr_eff;
  logic [K-2:0]       w_sr_next;
  logic               w_a;
  logic               w_b;

  // The first bit of a frame must see the preloaded state, not the stale sr
  assign w_s0      = init_to_state(bus.di_init);
  assign w_sr_eff  = (r_state == ST_IDLE) ? w_s0 : r_sr;
  assign w_sr_next = {w_sr_eff[K-3:0], bus.di};

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .i_bit (bus.di),
    .i_sr  (w_sr_eff),
    .o_a   (w_a),
    .o_b   (w_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_init_q  <= '0;
      r_cnt     <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
      r_tb_err  <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
      r_tb_err  <= 1'b0;
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.di_vld) begin
            r_init_q <= w_s0;
            r_sr     <= w_sr_next;
            r_cnt    <= CNT_W'(1);
            r_a      <= w_a;
            r_b      <= w_b;
            r_vld    <= 1'b1;
            r_state  <= ST_ENC;
          end
        end
        ST_ENC: begin
          if (bus.di_vld) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + CNT_W'(1);
            r_a   <= w_a;
            r_b   <= w_b;
            r_vld <= 1'b1;
            // Tail-biting holds when the final state returns to the preload
            if (r_cnt == CNT_W'(NUM_BITS - 1)) begin
              r_done   <= 1'b1;
              r_tb_err <= (w_sr_next != r_init_q);
              r_state  <= ST_IDLE;
            end
          end else begin
            r_len_err <= 1'b1;
            r_state   <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.do_a    = r_a;
  assign bus.do_b    = r_b;
  assign bus.do_vld  = r_vld;
  assign bus.do_done = r_done;
  assign bus.tb_err  = r_tb_err;
  assign bus.len_err = r_len_err;

endmodule

// File: tb/tb_signal_conv_enc.sv
// Directed bench for signal_conv_enc: reference tail-biting encoder feeds a
// scoreboard queue, a negedge monitor pops and compares every coded pair.
module tb_signal_conv_enc;

  localparam logic [6:0] REF_G0 = 7'o133;
  localparam logic [6:0] REF_G1 = 7'o171;
  localparam int         NB     = 32;

  typedef struct packed {
    logic a;
    logic b;
    logic done;
    logic tberr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t expQ [$];
  exp_t monE;
  int   total = 0;
  int   bad   = 0;

  signal_conv_enc_if bus ();

  signal_conv_enc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: bits before index 0 come from the tail (di_init)
  function automatic logic [1:0] refPair(input logic [31:0] word, input logic [5:0] init, input int i);
    logic a;
    logic b;
    logic p;
    int   idx;
    a = 1'b0;
    b = 1'b0;
    for (int j = 0; j < 7; j++) begin
      idx = i - j;
      p   = (idx >= 0) ? word[idx] : init[6 + idx];
      a   = a ^ (REF_G0[6-j] & p);
      b   = b ^ (REF_G1[6-j] & p);
    end
    return {a, b};
  endfunction

  task automatic applyStimulus(input logic [31:0] word, input logic [5:0] init, input int nbits);
    exp_t       e;
    logic [1:0] ab;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      #1;
      bus.di      = word[i];
      bus.di_init = init;
      bus.di_vld  = 1'b1;
      ab          = refPair(word, init, i);
      e.a         = ab[1];
      e.b         = ab[0];
      e.done      = (i == NB - 1);
      e.tberr     = (i == NB - 1) && (word[31:26] != init);
      expQ.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.di     = 1'b0;
      bus.di_vld = 1'b0;
    end
  endtask

  // Scoreboard monitor: every valid pair must match the oldest expectation
  always @(negedge clk) begin
    if (bus.do_vld === 1'b1) begin
      checkOutput("pair_pending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        monE = expQ.pop_front();
        checkOutput("do_a",    32'(bus.do_a),    32'(monE.a));
        checkOutput("do_b",    32'(bus.do_b),    32'(monE.b));
        checkOutput("do_done", 32'(bus.do_done), 32'(monE.done));
        checkOutput("tb_err",  32'(bus.tb_err),  32'(monE.tberr));
      end
    end else begin
      checkOutput("idle_a",    32'(bus.do_a),    32'd0);
      checkOutput("idle_b",    32'(bus.do_b),    32'd0);
      checkOutput("idle_done", 32'(bus.do_done), 32'd0);
      checkOutput("idle_tb",   32'(bus.tb_err),  32'd0);
    end
  end

  initial begin
    logic [31:0] w;
    bus.di      = 1'b0;
    bus.di_init = 6'h00;
    bus.di_vld  = 1'b0;
    rst_n       = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_vld",     32'(bus.do_vld),  32'd0);
    checkOutput("rst_len_err", 32'(bus.len_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All-zero, all-ones and impulse frames back to back
    applyStimulus(32'h0000_0000, 6'h00, NB);
    applyStimulus(32'hFFFF_FFFF, 6'h3F, NB);
    applyStimulus(32'h0000_0001, 6'h00, NB);
    idleCycles(3);

    // Wrong tail: bits 31:26 are 6'h3C but di_init says 0
    applyStimulus(32'hF004_00B1, 6'h00, NB);
    idleCycles(3);

    // Short frame followed by a full frame
    applyStimulus(32'hA5A5_1234, 6'h29, 10);
    @(posedge clk);
    #1;
    bus.di_vld = 1'b0;
    @(negedge clk);
    checkOutput("len_err_pre",   32'(bus.len_err), 32'd0);
    @(negedge clk);
    checkOutput("len_err_pulse", 32'(bus.len_err), 32'd1);
    @(negedge clk);
    checkOutput("len_err_post",  32'(bus.len_err), 32'd0);
    w = {$urandom_range(4095, 0), 4'($urandom_range(15, 0)), 16'($urandom_range(65535, 0))};
    applyStimulus(w, w[31:26], NB);
    idleCycles(2);

    // Back-to-back random frames, then reset in the middle of a third
    for (int f = 0; f < 2; f++) begin
      w = $urandom();
      applyStimulus(w, w[31:26], NB);
    end
    w = $urandom();
    applyStimulus(w, w[31:26], 15);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    bus.di_vld = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_vld",  32'(bus.do_vld),  32'd0);
    checkOutput("midrst_a",    32'(bus.do_a),    32'd0);
    checkOutput("midrst_done", 32'(bus.do_done), 32'd0);
    checkOutput("midrst_len",  32'(bus.len_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_len", 32'(bus.len_err), 32'd0);
    end
    w = $urandom();
    applyStimulus(w, w[31:26], NB);
    idleCycles(5);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
